// File: rtl/dm_pkg.sv
// Shared access-type codes and size decode for the data memory and the control unit.
package dm_pkg;

  localparam logic [2:0] DMT_W  = 3'b000;
  localparam logic [2:0] DMT_H  = 3'b100;
  localparam logic [2:0] DMT_HU = 3'b101;
  localparam logic [2:0] DMT_B  = 3'b110;
  localparam logic [2:0] DMT_BU = 3'b111;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } dm_size_e;

  // Codes 001/010/011 fall into the word case because only bit 2 is clear.
  function automatic dm_size_e dm_size(input logic [2:0] dm_type);
    if (!dm_type[2])     return SZ_WORD;
    else if (!dm_type[1]) return SZ_HALF;
    else                  return SZ_BYTE;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Memory-stage access bundle: the datapath drives address/data/type, the memory returns load data.
interface dm_if;
  logic        dm_w;
  logic [2:0]  dm_type;
  logic [31:0] wd;
  logic [31:0] a1;
  logic [31:0] rd1;

  modport master (output dm_w, output dm_type, output wd, output a1, input rd1);
  modport slave  (input dm_w, input dm_type, input wd, input a1, output rd1);
endinterface

// File: rtl/dm_ld_ext.sv
// Load extender: picks word/half/byte out of four little-endian raw bytes and sign/zero extends.
module dm_ld_ext
  import dm_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  dm_type_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    unique case (dm_size(dm_type_i))
      SZ_HALF: data_o = dm_type_i[0] ? {16'b0, raw_i[15:0]}
                                     : {{16{raw_i[15]}}, raw_i[15:0]};
      SZ_BYTE: data_o = dm_type_i[0] ? {24'b0, raw_i[7:0]}
                                     : {{24{raw_i[7]}}, raw_i[7:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dm.sv
// Byte-addressed data memory: synchronous little-endian stores, combinational extended loads.
module dm
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] addr [4];
  logic [3:0]    be;
  logic [31:0]   raw;
  logic [31:0]   ld_data;
  logic          unused_a1_hi;

  // Upper address bits alias onto the same storage.
  assign unused_a1_hi = ^bus.a1[31:AW];

  // Byte indices wrap naturally in the AW-bit adders.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr[k] = bus.a1[AW-1:0] + AW'(k);
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (dm_size(bus.dm_type))
      SZ_HALF: be = 4'b0011;
      SZ_BYTE: be = 4'b0001;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (bus.dm_w) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[addr[k]] <= bus.wd[8*k +: 8];
      end
    end
  end

  assign raw = {mem_q[addr[3]], mem_q[addr[2]], mem_q[addr[1]], mem_q[addr[0]]};

  dm_ld_ext u_ld_ext (
    .raw_i     (raw),
    .dm_type_i (bus.dm_type),
    .data_o    (ld_data)
  );

  assign bus.rd1 = reset ? 32'h0 : ld_data;

endmodule

// File: tb/tb_dm.sv
// Directed bench for dm: a table of store/load vectors plus hand sequences for reset and timing corners.
module tb_dm;
  import dm_pkg::*;

  localparam int DEPTH = 1024;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dm_if bus ();

  dm #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  t;
    logic [31:0] wd;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [2:0] t, input logic [31:0] wd,
                     input logic [31:0] a, input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.t = t; v.wd = wd; v.a = a; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] wd, input logic [31:0] a);
    @(negedge clk);
    bus.dm_w = 1'b1; bus.dm_type = t; bus.wd = wd; bus.a1 = a;
    @(posedge clk);
    #1;
    bus.dm_w = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] exp);
    bus.dm_type = t; bus.a1 = a;
    #1;
    check(name, bus.rd1, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.dm_w = 1'b0; bus.dm_type = DMT_W; bus.wd = 32'h0; bus.a1 = 32'h0;

    // Reset: rd1 forced low while held, memory zero afterwards.
    @(negedge clk);
    check("rst_hold", bus.rd1, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_read("rst_a0", DMT_W, 0, 32'h0);
    do_read("rst_a1", DMT_W, 1, 32'h0);
    do_read("rst_a100", DMT_W, 100, 32'h0);

    add(1, DMT_W,  32'hAAAAAAAA, 1,  0);
    add(0, DMT_W,  0, 1,  32'hAAAAAAAA);
    add(0, DMT_W,  0, 2,  32'h00AAAAAA);
    add(0, DMT_W,  0, 3,  32'h0000AAAA);
    add(0, DMT_W,  0, 4,  32'h000000AA);
    add(0, DMT_W,  0, 5,  32'h00000000);
    add(0, DMT_H,  0, 6,  32'h00000000);
    add(1, DMT_H,  32'hAAAAAAAA, 10, 0);
    add(1, DMT_B,  32'hAAAAAAAA, 15, 0);
    add(0, DMT_W,  0, 9,  32'h00AAAA00);
    add(0, DMT_W,  0, 12, 32'hAA000000);
    add(0, DMT_H,  0, 10, 32'hFFFFAAAA);
    add(0, DMT_HU, 0, 10, 32'h0000AAAA);
    add(0, DMT_B,  0, 4,  32'hFFFFFFAA);
    add(0, DMT_BU, 0, 4,  32'h000000AA);
    add(0, DMT_B,  0, 5,  32'h00000000);
    add(1, DMT_W,  32'h80017F02, 20, 0);
    add(0, DMT_H,  0, 20, 32'h00007F02);
    add(0, DMT_H,  0, 22, 32'hFFFF8001);
    add(0, DMT_HU, 0, 22, 32'h00008001);
    add(0, DMT_B,  0, 21, 32'h0000007F);
    add(0, DMT_B,  0, 23, 32'hFFFFFF80);
    add(0, DMT_BU, 0, 23, 32'h00000080);
    add(0, 3'b001, 0, 20, 32'h80017F02);
    add(0, 3'b011, 0, 21, 32'h0080017F);
    add(1, DMT_HU, 32'h1234BEEF, 30, 0);
    add(0, DMT_W,  0, 30, 32'h0000BEEF);
    add(1, DMT_BU, 32'hCCCCCC55, 33, 0);
    add(0, DMT_W,  0, 30, 32'h5500BEEF);
    add(1, 3'b010, 32'hDEADBEEF, 50, 0);
    add(0, DMT_W,  0, 50, 32'hDEADBEEF);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) do_write(vecs[i].t, vecs[i].wd, vecs[i].a);
      else do_read($sformatf("vec[%0d]", i), vecs[i].t, vecs[i].a, vecs[i].exp);
    end

    // Read-during-write: old data before the edge, new data right after.
    @(negedge clk);
    bus.dm_w = 1'b1; bus.dm_type = DMT_W; bus.wd = 32'hCAFEF00D; bus.a1 = 40;
    #1 check("rdw_before", bus.rd1, 32'h0);
    @(posedge clk);
    #1 check("rdw_after", bus.rd1, 32'hCAFEF00D);
    bus.dm_w = 1'b0;

    // Wrap-around store at the top of memory.
    do_write(DMT_W, 32'h11223344, DEPTH - 2);
    do_read("wrap_bu0", DMT_BU, 0, 32'h00000022);
    do_read("wrap_bu1", DMT_BU, 1, 32'h00000011);
    do_read("wrap_word", DMT_W, DEPTH - 2, 32'h11223344);
    do_read("wrap_hu", DMT_HU, DEPTH - 1, 32'h00002233);
    do_read("alias_word", DMT_W, 32'h0000_0400 + DEPTH - 2, 32'h11223344);

    // No store while dm_w is low, whatever wd does.
    bus.a1 = DEPTH - 2; bus.dm_type = DMT_W;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.wd = $urandom_range(32'hFFFF_FFFF, 0);
      @(posedge clk);
      #1 check($sformatf("nostore[%0d]", i), bus.rd1, 32'h11223344);
    end

    // Reset with a simultaneous store: store dropped, whole memory cleared.
    @(negedge clk);
    reset = 1'b1;
    bus.dm_w = 1'b1; bus.dm_type = DMT_W; bus.wd = 32'h12345678; bus.a1 = 8;
    #1 check("rst_force0", bus.rd1, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0; bus.dm_w = 1'b0;
    do_read("rst_prio_8", DMT_W, 8, 32'h0);
    do_read("rst_clr_1", DMT_W, 1, 32'h0);
    do_read("rst_clr_20", DMT_W, 20, 32'h0);
    do_read("rst_clr_wrap", DMT_W, DEPTH - 2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm.md
# dm

Byte-addressable data memory for the MIPS single-cycle datapath, sitting behind the ALU address output in the memory stage. It performs synchronous word/halfword/byte stores and combinational loads with sign or zero extension, selected by a 3-bit access-type code. Contents are cleared by a synchronous reset.

## Interface
- `DEPTH`, 1024, memory size in bytes (power of two).
- `AW`, `$clog2(DEPTH)`, number of address bits used.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears the whole memory.
- `dm_w`  in  1  store enable.
- `dm_type`  in  3  access type: 000 word, 100 half signed, 101 half unsigned, 110 byte signed, 111 byte unsigned.
- `wd`  in  32  store data; the low 32/16/8 bits are used according to size.
- `a1`  in  32  byte address; only `a1[AW-1:0]` is used, so upper bits alias.
- `rd1`  out  32  load data, extended to 32 bits.

## Operation
- Storage is an array of DEPTH bytes. Multi-byte accesses are little-endian: byte `a` is bits [7:0], byte `a+1` is [15:8], and so on.
- No alignment requirement. A word access touches bytes a..a+3 and a halfword access touches a..a+1. Byte indices wrap modulo DEPTH.
- Size decode:
  - `dm_type[2]`=0 means word.
  - `dm_type[2:1]`=10 means halfword.
  - `dm_type[2:1]`=11 means byte.
  - `dm_type[0]` selects unsigned (zero-extend) for loads.
  - Codes 001, 010 and 011 behave as word.
- Store: on a rising edge with `reset`=0 and `dm_w`=1, write the size-selected low bytes of `wd`. Bytes outside the access are unchanged. The unsigned codes store exactly like the signed ones.
- Load: `rd1` is a combinational function of the current contents, `a1` and `dm_type`. Loads occur regardless of `dm_w`.
  - Word: the 4 bytes as read.
  - Half signed: `{{16{h[15]}},h}`. Half unsigned: `{16'b0,h}`.
  - Byte signed: `{{24{b[7]}},b}`. Byte unsigned: `{24'b0,b}`.
- Reset: on a rising edge with `reset`=1, every byte becomes 0x00. Reset has priority over a simultaneous store, and that store is dropped.
- While `reset`=1, `rd1` is forced to 0.

## Timing
- Store latency: one edge. Data written at edge N is visible on `rd1` right after edge N, with no extra cycle.
- Load latency: zero cycles. `rd1` settles combinationally from `a1`/`dm_type` changes.
- Read-during-write at the same address: `rd1` shows old data before the edge and new data after it. There is no write-through bypass.
- `rd1` reset value: 0, both during reset and in the cycle after it, because the memory is all zero.
- Reset mid-operation: any pending store on that edge is lost, and the memory is cleared in a single edge.

## Structure
- Shared package `dm_pkg`:
  - constants `DMT_W`=3'b000, `DMT_H`=3'b100, `DMT_HU`=3'b101, `DMT_B`=3'b110, `DMT_BU`=3'b111;
  - a size-decode helper function.
  - The decoder/control unit uses the same constants.
- One sub-module is natural: `dm_ld_ext`, the combinational load aligner/extender. It takes 4 raw bytes and `dm_type` and produces the 32-bit result.
- The top level holds the byte array, address wrap logic, store byte enables and reset clear.

## Test plan
- Reset then read: hold `reset`=1 for one edge, then read a word at addresses 0, 1 and 100 → `rd1`=0x00000000 each.
- Unaligned word store:
  - Store `wd`=0xAAAAAAAA as a word at `a1`=1.
  - Word reads then return: at 1 → 0xAAAAAAAA; at 2 → 0x00AAAAAA; at 3 → 0x0000AAAA; at 4 → 0x000000AA; at 5 → 0x00000000.
  - Half signed at 6 → 0x00000000.
- Half and byte stores:
  - After the above, store half 0xAAAAAAAA at 10 and byte at 15.
  - Word read at 9 → 0x00AAAA00. Word read at 12 → 0xAA000000.
  - Half signed at 10 → 0xFFFFAAAA; half unsigned at 10 → 0x0000AAAA.
- Byte extension: byte signed at 4 → 0xFFFFFFAA; byte unsigned at 4 → 0x000000AA; byte signed at 5 → 0x00000000.
- Reset priority: assert `reset` and `dm_w`=1 with a word 0x12345678 at 8 on the same edge, then read a word at 8 → 0x00000000.
- Wrap-around and no-store:
  - Store word 0x11223344 at DEPTH-2, then read byte unsigned at 0 → 0x22 and at 1 → 0x11.
  - With `dm_w`=0 and `wd` changing, the contents stay unchanged.
